// File: rtl/fb_pkg.sv
// fb_pkg: shared fill state and mode encodings plus frame geometry helpers
package fb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;
    localparam logic FILL_MODE_FULL = 1'b0;
    localparam logic FILL_MODE_RECT = 1'b1;
    function automatic int line_pixels(input int frame_width, input int scaling_factor);
        return frame_width / scaling_factor;
    endfunction
    function automatic int line_count(input int frame_height, input int scaling_factor);
        return frame_height / scaling_factor;
    endfunction
endpackage

// File: rtl/fb_raster_addr_gen.sv
// fb_raster_addr_gen: clips a rectangle to the frame and walks it in raster order
module fb_raster_addr_gen #(
    parameter int LINE_PIXELS = 640,
    parameter int LINE_COUNT = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int COORD_WIDTH = 10
) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic step,
    input logic [COORD_WIDTH-1:0] x0,
    input logic [COORD_WIDTH-1:0] y0,
    input logic [COORD_WIDTH-1:0] w,
    input logic [COORD_WIDTH-1:0] h,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic last,
    output logic empty
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] LP = AW'(LINE_PIXELS);
    localparam logic [AW-1:0] LC = AW'(LINE_COUNT);
    logic [AW-1:0] xe, ye, we, he, rem_x, rem_y, w_clip, h_clip, start_addr, row_step;
    logic [AW-1:0] col, row, w_eff, h_eff;
    always_comb begin
        xe = AW'(x0);
        ye = AW'(y0);
        we = AW'(w);
        he = AW'(h);
        rem_x = LP - xe;
        rem_y = LC - ye;
        w_clip = we < rem_x ? we : rem_x;
        h_clip = he < rem_y ? he : rem_y;
        start_addr = ye * LP + xe;
        row_step = LP - w_eff + AW'(1);
        empty = w == '0 || h == '0 || xe >= LP || ye >= LC;
        last = col == w_eff - AW'(1) && row == h_eff - AW'(1);
    end
    // the final pixel holds its address so the counter never leaves the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            col <= '0;
            row <= '0;
            w_eff <= '0;
            h_eff <= '0;
        end else if (load) begin
            addr <= start_addr;
            col <= '0;
            row <= '0;
            w_eff <= w_clip;
            h_eff <= h_clip;
        end else if (step && !last) begin
            if (col == w_eff - AW'(1)) begin
                col <= '0;
                row <= row + AW'(1);
                addr <= addr + row_step;
            end else begin
                col <= col + AW'(1);
                addr <= addr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/fb_region_fill.sv
// fb_region_fill: full-frame or rectangle fill engine sharing the framebuffer port with a user path
module fb_region_fill
    import fb_pkg::*;
#(
    parameter int FRAME_WIDTH = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int SCALING_FACTOR = 1,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int COORD_WIDTH = 10
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic mode,
    input logic [COORD_WIDTH-1:0] x0,
    input logic [COORD_WIDTH-1:0] y0,
    input logic [COORD_WIDTH-1:0] w,
    input logic [COORD_WIDTH-1:0] h,
    input logic [DATA_WIDTH-1:0] color,
    input logic abort,
    output logic busy,
    output logic done,
    input logic usr_en,
    input logic [ADDR_WIDTH-1:0] usr_addr,
    input logic [DATA_WIDTH-1:0] usr_din,
    output logic usr_ready,
    output logic mem_en,
    output logic mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);
    localparam int LINE_PIXELS = line_pixels(FRAME_WIDTH, SCALING_FACTOR);
    localparam int LINE_COUNT = line_count(FRAME_HEIGHT, SCALING_FACTOR);
    fill_state_t state;
    logic mode_q;
    logic [COORD_WIDTH-1:0] x0_q, y0_q, w_q, h_q, gx0, gy0, gw, gh;
    logic [DATA_WIDTH-1:0] color_q;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic last, empty, filling, pass;
    always_comb begin
        gx0 = mode_q == FILL_MODE_FULL ? '0 : x0_q;
        gy0 = mode_q == FILL_MODE_FULL ? '0 : y0_q;
        gw = mode_q == FILL_MODE_FULL ? COORD_WIDTH'(LINE_PIXELS) : w_q;
        gh = mode_q == FILL_MODE_FULL ? COORD_WIDTH'(LINE_COUNT) : h_q;
        filling = state == FILL;
        pass = state == IDLE || state == DONE;
        usr_ready = !rst && pass;
        mem_en = !rst && (filling || (pass && usr_en));
        mem_we = mem_en;
        mem_addr = filling ? fill_addr : usr_addr;
        mem_din = filling ? color_q : usr_din;
    end
    fb_raster_addr_gen #(
        .LINE_PIXELS(LINE_PIXELS),
        .LINE_COUNT(LINE_COUNT),
        .ADDR_WIDTH(ADDR_WIDTH),
        .COORD_WIDTH(COORD_WIDTH)
    ) u_addr_gen (
        .clk(clk),
        .rst(rst),
        .load(state == SETUP),
        .step(filling),
        .x0(gx0),
        .y0(gy0),
        .w(gw),
        .h(gh),
        .addr(fill_addr),
        .last(last),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            mode_q <= 1'b0;
            x0_q <= '0;
            y0_q <= '0;
            w_q <= '0;
            h_q <= '0;
            color_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= SETUP;
                    busy <= 1'b1;
                    mode_q <= mode;
                    x0_q <= x0;
                    y0_q <= y0;
                    w_q <= w;
                    h_q <= h;
                    color_q <= color;
                end
                SETUP: if (abort) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (empty) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    state <= FILL;
                end
                FILL: if (abort) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (last) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_region_fill.sv
// tb_fb_region_fill: randomized and directed checks of fb_region_fill against a pixel-membership model
module tb_fb_region_fill;
    localparam int LP = 8, LC = 4, AW = 19, DW = 8, CW = 10;
    logic clk = 1'b0;
    logic rst, start, mode, abort, usr_en;
    logic [CW-1:0] x0, y0, w, h;
    logic [DW-1:0] color, usr_din, mem_din;
    logic [AW-1:0] usr_addr, mem_addr;
    logic busy, done, usr_ready, mem_en, mem_we;
    int vectors = 0, miscompares = 0;
    int got_a[$], got_d[$], got_n[$], exp_a[$];
    int done_n, done_cnt, busy_cnt, rdy_bad, we_bad;
    bit timed_out;

    always #5 clk = ~clk;

    fb_region_fill #(
        .FRAME_WIDTH(LP), .FRAME_HEIGHT(LC), .SCALING_FACTOR(1),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COORD_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(color), .abort(abort),
        .busy(busy), .done(done),
        .usr_en(usr_en), .usr_addr(usr_addr), .usr_din(usr_din), .usr_ready(usr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
    );

    // every frame pixel inside the requested rectangle, visited in raster order
    function automatic void model(input logic m, input int mx, input int my, input int mw, input int mh);
        exp_a.delete();
        if (m == 1'b0) begin
            mx = 0; my = 0; mw = LP; mh = LC;
        end
        for (int y = 0; y < LC; y++)
            for (int x = 0; x < LP; x++)
                if (x >= mx && x < mx + mw && y >= my && y < my + mh) exp_a.push_back(y * LP + x);
    endfunction

    task automatic launch(input logic m, input int sx, input int sy, input int sw, input int sh, input logic [DW-1:0] c);
        @(posedge clk); #1;
        start = 1'b1; mode = m; x0 = CW'(sx); y0 = CW'(sy); w = CW'(sw); h = CW'(sh); color = c;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom); w = CW'($urandom); h = CW'($urandom);
        color = DW'($urandom); mode = 1'($urandom);
    endtask

    task automatic collect();
        got_a.delete(); got_d.delete(); got_n.delete();
        done_n = -1; done_cnt = 0; busy_cnt = 0; rdy_bad = 0; we_bad = 0; timed_out = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (mem_en && (busy || !usr_en)) begin
                got_a.push_back(int'(mem_addr)); got_d.push_back(int'(mem_din)); got_n.push_back(n);
            end
            if (mem_en !== mem_we) we_bad++;
            if (busy) busy_cnt++;
            if (busy && usr_ready) rdy_bad++;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; usr_en = 1'b1;
        usr_addr = AW'(3); usr_din = 8'h99; x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
        vectors++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en got=%b/%b exp=0/0", mem_en, mem_we); end
        vectors++; if (usr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_usr_ready got=%b exp=0", usr_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (usr_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== AW'(3) || mem_din !== 8'h99) begin
            miscompares++; $display("FAIL idle_pass got rdy=%b en=%b addr=%0d din=%h exp 1 1 3 99", usr_ready, mem_en, mem_addr, mem_din);
        end
        usr_en = 1'b0;
    endtask

    task automatic test_full_fill();
        launch(1'b0, 3, 2, 1, 1, 8'h5A);
        collect();
        model(1'b0, 0, 0, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL full_timeout got=busy exp=idle"); end
        vectors++; if (got_a.size() != 32) begin miscompares++; $display("FAIL full_count got=%0d exp=32", got_a.size()); end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            vectors++;
            if (got_a[i] != exp_a[i] || got_d[i] != 'h5A || got_n[i] != 2 + i) begin
                miscompares++; $display("FAIL full_write[%0d] got a=%0d d=%h n=%0d exp a=%0d d=5a n=%0d", i, got_a[i], got_d[i], got_n[i], exp_a[i], 2 + i);
            end
        end
        vectors++; if (done_cnt != 1 || done_n != 34) begin miscompares++; $display("FAIL full_done got cnt=%0d n=%0d exp 1 34", done_cnt, done_n); end
        vectors++; if (busy_cnt != 33) begin miscompares++; $display("FAIL full_busy got=%0d exp=33", busy_cnt); end
        vectors++; if (we_bad != 0) begin miscompares++; $display("FAIL full_we got=%0d exp=0", we_bad); end
    endtask

    task automatic test_rect_and_clip();
        int ref_rect[6] = '{10, 11, 12, 18, 19, 20};
        launch(1'b1, 2, 1, 3, 2, 8'hC3);
        collect();
        vectors++; if (got_a.size() != 6) begin miscompares++; $display("FAIL rect_count got=%0d exp=6", got_a.size()); end
        for (int i = 0; i < got_a.size() && i < 6; i++) begin
            vectors++;
            if (got_a[i] != ref_rect[i] || got_d[i] != 'hC3) begin
                miscompares++; $display("FAIL rect_write[%0d] got a=%0d d=%h exp a=%0d d=c3", i, got_a[i], got_d[i], ref_rect[i]);
            end
        end
        vectors++; if (done_cnt != 1 || done_n != 8) begin miscompares++; $display("FAIL rect_done got cnt=%0d n=%0d exp 1 8", done_cnt, done_n); end
        launch(1'b1, 6, 3, 5, 5, 8'h42);
        collect();
        vectors++; if (got_a.size() != 2 || (got_a.size() == 2 && (got_a[0] != 30 || got_a[1] != 31))) begin
            miscompares++; $display("FAIL clip_addrs got n=%0d first=%0d exp n=2 30,31", got_a.size(), got_a.size() > 0 ? got_a[0] : -1);
        end
        vectors++; if (done_n != 4) begin miscompares++; $display("FAIL clip_done got=%0d exp=4", done_n); end
        launch(1'b1, 8, 0, 3, 3, 8'h42);
        collect();
        vectors++; if (got_a.size() != 0) begin miscompares++; $display("FAIL empty_writes got=%0d exp=0", got_a.size()); end
        vectors++; if (done_n != 2 || done_cnt != 1 || busy_cnt != 1) begin
            miscompares++; $display("FAIL empty_done got n=%0d cnt=%0d busy=%0d exp 2 1 1", done_n, done_cnt, busy_cnt);
        end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; x0 = CW'(1); y0 = '0; w = CW'(4); h = CW'(2); color = 8'h77;
        usr_en = 1'b1; usr_addr = AW'(7); usr_din = 8'h33;
        @(negedge clk);
        vectors++; if (mem_en !== 1'b1 || mem_addr !== AW'(7) || mem_din !== 8'h33 || usr_ready !== 1'b1) begin
            miscompares++; $display("FAIL cont_user got en=%b addr=%0d din=%h rdy=%b exp 1 7 33 1", mem_en, mem_addr, mem_din, usr_ready);
        end
        @(posedge clk); #1;
        start = 1'b0; usr_addr = AW'(5); usr_din = 8'hEE;
        collect();
        usr_en = 1'b0;
        model(1'b1, 1, 0, 4, 2);
        vectors++; if (rdy_bad != 0) begin miscompares++; $display("FAIL cont_ready got=%0d exp=0", rdy_bad); end
        vectors++; if (got_a.size() != exp_a.size()) begin miscompares++; $display("FAIL cont_count got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            vectors++;
            if (got_a[i] != exp_a[i] || got_d[i] != 'h77) begin
                miscompares++; $display("FAIL cont_write[%0d] got a=%0d d=%h exp a=%0d d=77", i, got_a[i], got_d[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_abort();
        int cnt = 0;
        launch(1'b0, 0, 0, 0, 0, 8'h11);
        for (int n = 0; n < 50 && cnt < 4; n++) begin
            @(negedge clk);
            if (mem_en) cnt++;
        end
        abort = 1'b1;
        @(negedge clk);
        vectors++; if (cnt != 4) begin miscompares++; $display("FAIL abort_writes got=%0d exp=4", cnt); end
        vectors++; if (busy !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL abort_after got busy=%b en=%b done=%b exp 0 0 0", busy, mem_en, done);
        end
        abort = 1'b0; start = 1'b1; mode = 1'b1; x0 = CW'(5); y0 = CW'(2); w = CW'(2); h = CW'(1); color = 8'h66;
        @(posedge clk); #1;
        start = 1'b0;
        collect();
        model(1'b1, 5, 2, 2, 1);
        vectors++; if (got_a.size() != 2 || done_cnt != 1 || (got_a.size() == 2 && (got_a[0] != exp_a[0] || got_a[1] != exp_a[1]))) begin
            miscompares++; $display("FAIL abort_restart got n=%0d done=%0d exp n=2 (%0d,%0d) done=1", got_a.size(), done_cnt, exp_a[0], exp_a[1]);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || usr_ready !== 1'b1) begin miscompares++; $display("FAIL idle_abort got busy=%b rdy=%b exp 0 1", busy, usr_ready); end
        @(posedge clk); #1;
        abort = 1'b0;
        launch(1'b1, 0, 1, 3, 1, 8'hA5);
        start = 1'b1; mode = 1'b1; x0 = '0; y0 = '0; w = CW'(1); h = CW'(1);
        collect();
        start = 1'b0;
        model(1'b1, 0, 1, 3, 1);
        vectors++; if (got_a.size() != 3 || (got_a.size() == 3 && (got_a[0] != exp_a[0] || got_a[2] != exp_a[2])) || done_cnt != 1) begin
            miscompares++; $display("FAIL busy_start got n=%0d done=%0d exp n=3 from %0d done=1", got_a.size(), done_cnt, exp_a[0]);
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle got busy=%b en=%b exp 0 0", busy, mem_en); end
    endtask

    task automatic test_rst_mid_fill();
        int cnt = 0;
        launch(1'b0, 0, 0, 0, 0, 8'h3C);
        for (int n = 0; n < 50 && cnt < 5; n++) begin
            @(negedge clk);
            if (mem_en) cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || usr_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid got en=%b busy=%b done=%b rdy=%b exp 0 0 0 0", mem_en, busy, done, usr_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            vectors++; if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++; $display("FAIL rst_mid_after[%0d] got en=%b busy=%b done=%b exp 0 0 0", n, mem_en, busy, done);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            logic m;
            int rx, ry, rw, rh;
            logic [DW-1:0] c;
            m = $urandom_range(0, 3) != 0;
            rx = $urandom_range(0, 9); ry = $urandom_range(0, 5);
            rw = $urandom_range(0, 10); rh = $urandom_range(0, 6);
            c = DW'($urandom);
            launch(m, rx, ry, rw, rh, c);
            collect();
            model(m, rx, ry, rw, rh);
            vectors++; if (timed_out || got_a.size() != exp_a.size()) begin
                miscompares++; $display("FAIL rand%0d_count got=%0d exp=%0d (m=%b x=%0d y=%0d w=%0d h=%0d)", t, got_a.size(), exp_a.size(), m, rx, ry, rw, rh);
            end
            for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
                vectors++;
                if (got_a[i] != exp_a[i] || got_d[i] != int'(c) || got_n[i] != 2 + i) begin
                    miscompares++; $display("FAIL rand%0d_write[%0d] got a=%0d d=%h n=%0d exp a=%0d d=%h n=%0d", t, i, got_a[i], got_d[i], got_n[i], exp_a[i], c, 2 + i);
                end
            end
            vectors++; if (done_cnt != 1 || done_n != 2 + exp_a.size() || busy_cnt != 1 + exp_a.size()) begin
                miscompares++; $display("FAIL rand%0d_done got cnt=%0d n=%0d busy=%0d exp 1 %0d %0d", t, done_cnt, done_n, busy_cnt, 2 + exp_a.size(), 1 + exp_a.size());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_fill();
        test_rect_and_clip();
        test_contention();
        test_abort();
        test_back_to_back();
        test_rst_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
